// File: rtl/uart_rx_term_capture.sv
// UART 8N1 receiver (LSB first) feeding a show-ahead byte FIFO, with newline/frame-error pulses and sticky overflow.
// Latency: byte is pushed one cycle after the stop-bit sample, so it is visible on rd_data two cycles after that sample.
// Backpressure: none toward the line; a byte arriving while full is dropped (overflow), unless popped in the same cycle.
//
// Ports:
//   HCLK, HRESETn      clock, synchronous active-low reset
//   rx                 serial line, idle high, asynchronous to HCLK
//   rd_en              pop head (ignored when empty)
//   clr_err            clear sticky overflow
//   rd_data            head byte (8'h00 while empty)
//   empty/full/count   FIFO occupancy
//   newline            one-cycle pulse when 0x0A is pushed
//   frame_err          one-cycle pulse on a bad stop bit
//   overflow           sticky drop indicator
module uart_rx_term_capture #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            rx,
    input  logic                            rd_en,
    input  logic                            clr_err,
    output logic [7:0]                      rd_data,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            newline,
    output logic                            frame_err,
    output logic                            overflow
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rxs;
    logic [TW-1:0]   timer, timer_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            stop_ok, stop_bad;

    logic            push_pend;
    logic [7:0]      push_byte;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            pop_ok, do_push, drop;

    // ---------------- receiver ----------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= ST_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + TW'(1);
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (!rxs) begin
                    state_nxt   = ST_START;
                    bit_cnt_nxt = '0;
                end
            end
            ST_START: begin
                // mid-start-bit check rejects short glitches silently
                if (timer == HALF_LAST) begin
                    timer_nxt = '0;
                    state_nxt = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    shift_nxt = {rxs, shift[7:1]};
                    if (bit_cnt == 3'd7) state_nxt = ST_STOP;
                    else                 bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            ST_STOP: begin
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    if (rxs) begin
                        stop_ok   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // line held low: wait for idle before looking for a new start
                timer_nxt = '0;
                if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stop sample is registered; the push and its newline flag land together in the following cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            push_pend <= 1'b0;
            push_byte <= '0;
            newline   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_pend <= stop_ok;
            push_byte <= shift;
            newline   <= stop_ok && (shift == 8'h0A);
            frame_err <= stop_bad;
        end
    end

    // ---------------- FIFO ----------------
    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop_ok  = rd_en && !empty;
    // a pop in the same cycle frees the slot, so push still succeeds when full
    assign do_push = push_pend && (!full || pop_ok);
    assign drop    = push_pend && full && !rd_en;
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(pop_ok);
            // a new drop wins over a simultaneous clear
            if (drop)         overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

endmodule
